// File: rtl/player_ctrl.sv
// Beat sequencer: divides clk into beat ticks and steps the beat index fed to the
// tone lookup stage, with play / pause / stop / loop control and status pulses.
module player_ctrl #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BEAT_HZ  = 8,
  parameter int BEAT_LEN = 60
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       play_i,
  input  logic       pause_i,
  input  logic       stop_i,
  input  logic       loop_en_i,
  output logic [7:0] beat_num_o,
  output logic       playing_o,
  output logic       mute_o,
  output logic       beat_tick_o,
  output logic       done_o
);

  localparam int CNT_MAX = CLK_FREQ / BEAT_HZ - 1;
  localparam int CW      = (CNT_MAX + 1 > 2) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CNT_MAX);
  localparam logic [7:0]    BEAT_LAST = 8'(BEAT_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] div_q, div_d;
  logic [7:0]    beat_q, beat_d;
  logic          playing_q, playing_d;
  logic          mute_q, mute_d;
  logic          tick_q, tick_d;
  logic          done_q, done_d;

  // Next-state decode; command priority is stop > pause > play.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    beat_d  = beat_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        div_d  = '0;
        beat_d = 8'd0;
        if (!stop_i && !pause_i && play_i) begin
          state_d = ST_PLAY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PLAY: begin
        if (stop_i) begin
          state_d = ST_IDLE;
          div_d   = '0;
          beat_d  = 8'd0;
        end else if (pause_i) begin
          state_d = ST_PAUSE;
        end else if (div_q == CNT_LAST) begin
          div_d = '0;
          if (beat_q != BEAT_LAST) begin
            beat_d = beat_q + 8'd1;
            tick_d = 1'b1;
          end else if (loop_en_i) begin
            beat_d = 8'd0;
            tick_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            beat_d  = 8'd0;
            done_d  = 1'b1;
          end
        end else begin
          div_d = div_q + CW'(1);
        end
      end
      ST_PAUSE: begin
        if (stop_i) begin
          state_d = ST_IDLE;
          div_d   = '0;
          beat_d  = 8'd0;
        end else if (!pause_i && play_i) begin
          state_d = ST_PLAY;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        div_d   = '0;
        beat_d  = 8'd0;
      end
    endcase
    // Status flags follow the upcoming state so they line up with it.
    playing_d = (state_d == ST_PLAY);
    mute_d    = (state_d != ST_PLAY);
  end

  // State and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      beat_q    <= 8'd0;
      playing_q <= 1'b0;
      mute_q    <= 1'b1;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      beat_q    <= beat_d;
      playing_q <= playing_d;
      mute_q    <= mute_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
    end
  end

  assign beat_num_o  = beat_q;
  assign playing_o   = playing_q;
  assign mute_o      = mute_q;
  assign beat_tick_o = tick_q;
  assign done_o      = done_q;

endmodule
